// File: rtl/bnn_seq_pkg.sv
// Shared types and default phase lengths for the BNN sequencing controller.
// The watchdog timeout constant is only consumed when BNN_SEQ_TIMEOUT_EN is defined.
package bnn_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CONV_LD  = 3'd1,
        ST_IMG      = 3'd2,
        ST_FC       = 3'd3,
        ST_WAIT_RES = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    localparam int DEF_KERNEL_TAPS = 9;
    localparam int DEF_NUM_KERNELS = 2;
    localparam int DEF_IMG_PIXELS  = 784;
    localparam int DEF_FC_BEATS    = 338;
    localparam int DEF_TIMEOUT_CYC = 4096;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bnn_beat_cnt.sv
// Loadable beat counter; tc_o flags the last beat of the current phase.
// An increment on the terminal count returns to zero, so it never wraps past last_i.
module bnn_beat_cnt #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         inc_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o  = (cnt_q == last_i);
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bnn_seq_ctrl.sv
// Sequences conv weights, image pixels and FC weights from one serial source.
// Define BNN_SEQ_TIMEOUT_EN to add the WAIT_RES watchdog (err / class 4'hF).
module bnn_seq_ctrl
    import bnn_seq_pkg::*;
#(
    parameter int KERNEL_TAPS = DEF_KERNEL_TAPS,
    parameter int NUM_KERNELS = DEF_NUM_KERNELS,
    parameter int IMG_PIXELS  = DEF_IMG_PIXELS,
    parameter int FC_BEATS    = DEF_FC_BEATS,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   src_valid,
    input  logic [9:0]             src_data,
    output logic                   src_ready,
    input  logic                   core_fc_req,
    input  logic                   core_done,
    input  logic [3:0]             core_class,
    output logic [NUM_KERNELS-1:0] conv_w_en,
    output logic                   conv_w_bit,
    output logic                   pix_valid,
    output logic                   pix_bit,
    output logic                   fc_wvalid,
    output logic [9:0]             fc_w,
    output logic                   busy,
    output logic                   done,
    output logic [3:0]             class_out,
    output logic                   err
);

    localparam int CONV_LEN = NUM_KERNELS * KERNEL_TAPS;
    localparam int MAX_LEN  = max3(CONV_LEN, IMG_PIXELS, FC_BEATS);
    localparam int CW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt, last;
    logic                   tc, accept, start_acc, wd_hit;
    logic [NUM_KERNELS-1:0] kern_sel;

    logic [NUM_KERNELS-1:0] conv_w_en_q, conv_w_en_d;
    logic                   conv_w_bit_q, conv_w_bit_d;
    logic                   pix_valid_q, pix_valid_d;
    logic                   pix_bit_q, pix_bit_d;
    logic                   fc_wvalid_q, fc_wvalid_d;
    logic [9:0]             fc_w_q, fc_w_d;
    logic [3:0]             class_q, class_d;

    assign accept    = src_valid & src_ready;
    assign start_acc = (state_q == ST_IDLE) & start;

    bnn_beat_cnt #(.W(CW)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (start_acc),
        .inc_i  (accept),
        .last_i (last),
        .cnt_o  (cnt),
        .tc_o   (tc)
    );

    always_comb begin
        last = '0;
        unique case (state_q)
            ST_CONV_LD: last = CW'(CONV_LEN - 1);
            ST_IMG:     last = CW'(IMG_PIXELS - 1);
            ST_FC:      last = CW'(FC_BEATS - 1);
            default:    last = '0;
        endcase
    end

    // Kernel slot n/KERNEL_TAPS found by range compare instead of a divider
    always_comb begin
        kern_sel = '0;
        for (int k = 0; k < NUM_KERNELS; k++) begin
            kern_sel[k] = (cnt >= CW'(k * KERNEL_TAPS)) &&
                          (cnt <  CW'((k + 1) * KERNEL_TAPS));
        end
    end

`ifdef BNN_SEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          err_q, err_d;

    assign wd_d   = (state_q == ST_WAIT_RES) ? wd_q + 1'b1 : '0;
    assign wd_hit = (state_q == ST_WAIT_RES) && !core_done &&
                    (wd_q == WW'(TIMEOUT_CYC - 1));

    always_comb begin
        err_d = err_q;
        if (start_acc) begin
            err_d = 1'b0;
        end else if (wd_hit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign wd_hit = 1'b0;
    assign err    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (start) state_d = ST_CONV_LD;
            ST_CONV_LD:  if (accept && tc) state_d = ST_IMG;
            ST_IMG:      if (accept && tc) state_d = ST_FC;
            ST_FC:       if (accept && tc) state_d = ST_WAIT_RES;
            ST_WAIT_RES: if (core_done || wd_hit) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        src_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            ST_IDLE:     busy = 1'b0;
            ST_CONV_LD:  src_ready = 1'b1;
            ST_IMG:      src_ready = 1'b1;
            ST_FC:       src_ready = core_fc_req;
            ST_WAIT_RES: src_ready = 1'b0;
            ST_DONE:     done = 1'b1;
            default:     busy = 1'b0;
        endcase
    end

    always_comb begin
        conv_w_en_d  = '0;
        conv_w_bit_d = 1'b0;
        pix_valid_d  = 1'b0;
        pix_bit_d    = 1'b0;
        fc_wvalid_d  = 1'b0;
        fc_w_d       = '0;
        class_d      = class_q;
        if (accept && state_q == ST_CONV_LD) begin
            conv_w_en_d  = kern_sel;
            conv_w_bit_d = src_data[0];
        end
        if (accept && state_q == ST_IMG) begin
            pix_valid_d = 1'b1;
            pix_bit_d   = src_data[0];
        end
        if (accept && state_q == ST_FC) begin
            fc_wvalid_d = 1'b1;
            fc_w_d      = src_data;
        end
        if (start_acc) begin
            class_d = 4'h0;
        end else if (state_q == ST_WAIT_RES && core_done) begin
            class_d = core_class;
        end else if (wd_hit) begin
            class_d = 4'hF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_w_en_q  <= '0;
            conv_w_bit_q <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_bit_q    <= 1'b0;
            fc_wvalid_q  <= 1'b0;
            fc_w_q       <= '0;
            class_q      <= 4'h0;
        end else begin
            conv_w_en_q  <= conv_w_en_d;
            conv_w_bit_q <= conv_w_bit_d;
            pix_valid_q  <= pix_valid_d;
            pix_bit_q    <= pix_bit_d;
            fc_wvalid_q  <= fc_wvalid_d;
            fc_w_q       <= fc_w_d;
            class_q      <= class_d;
        end
    end

    assign conv_w_en  = conv_w_en_q;
    assign conv_w_bit = conv_w_bit_q;
    assign pix_valid  = pix_valid_q;
    assign pix_bit    = pix_bit_q;
    assign fc_wvalid  = fc_wvalid_q;
    assign fc_w       = fc_w_q;
    assign class_out  = class_q;

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// Scoreboard bench for bnn_seq_ctrl: randomized source traffic vs. a beat-index model.
// Define BNN_SEQ_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYC=16).
module tb_bnn_seq_ctrl;

    localparam int KT    = 9;
    localparam int NK    = 2;
    localparam int PIX   = 784;
    localparam int FCB   = 338;
    localparam int TO    = 16;
    localparam int CONV  = NK * KT;
    localparam int TOTAL = CONV + PIX + FCB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       src_valid = 1'b0;
    logic [9:0] src_data = '0;
    logic       src_ready;
    logic       core_fc_req = 1'b0;
    logic       core_done = 1'b0;
    logic [3:0] core_class = '0;
    logic [1:0] conv_w_en;
    logic       conv_w_bit, pix_valid, pix_bit, fc_wvalid;
    logic [9:0] fc_w;
    logic       busy, done, err;
    logic [3:0] class_out;

    bnn_seq_ctrl #(
        .KERNEL_TAPS (KT),
        .NUM_KERNELS (NK),
        .IMG_PIXELS  (PIX),
        .FC_BEATS    (FCB),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_ready   (src_ready),
        .core_fc_req (core_fc_req),
        .core_done   (core_done),
        .core_class  (core_class),
        .conv_w_en   (conv_w_en),
        .conv_w_bit  (conv_w_bit),
        .pix_valid   (pix_valid),
        .pix_bit     (pix_bit),
        .fc_wvalid   (fc_wvalid),
        .fc_w        (fc_w),
        .busy        (busy),
        .done        (done),
        .class_out   (class_out),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        logic [1:0] en;
        logic       cb;
        logic       pv;
        logic       pb;
        logic       fv;
        logic [9:0] fw;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   beat = 0;
    int   drops = 0;
    int   n_conv = 0, n_pix = 0, n_fc = 0, n_done = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Phase of the beat with a given index: 1 conv, 2 image, 3 FC, 4 waiting
    function automatic int phase_of(input int b);
        if (b < CONV) return 1;
        if (b < CONV + PIX) return 2;
        if (b < TOTAL) return 3;
        return 4;
    endfunction

    // Monitor: pops one expectation per observed output beat
    always @(posedge clk) begin
        logic outp;
        exp_t e;
        cyc++;
        #1;
        outp = (conv_w_en != 2'b00) || pix_valid || fc_wvalid;
        if (done) n_done++;
        if (conv_w_en != 2'b00) n_conv++;
        if (pix_valid) n_pix++;
        if (fc_wvalid) n_fc++;
        if (outp) begin
            chk("sb_nonempty", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("sb_lag", cyc, e.tag);
                chk("conv_w_en", conv_w_en, e.en);
                chk("pix_valid", pix_valid, e.pv);
                chk("fc_wvalid", fc_wvalid, e.fv);
                if (e.en != 2'b00) chk("conv_w_bit", conv_w_bit, e.cb);
                if (e.pv) chk("pix_bit", pix_bit, e.pb);
                if (e.fv) chk("fc_w", fc_w, e.fw);
            end
        end else if (sbq.size() != 0 && sbq[0].tag <= cyc) begin
            chk("sb_missing", outp, 1);
            void'(sbq.pop_front());
        end
    end

    task automatic start_run();
        start = 1'b1;
        beat = 0;
        drops = 0;
        n_conv = 0;
        n_pix = 0;
        n_fc = 0;
        n_done = 0;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("ready_conv", src_ready, 1);
    endtask

    // Drives random beats until stop_at beats are accepted (model view)
    task automatic stream(input int stop_at);
        int   guard;
        int   ph;
        logic rdy;
        exp_t e;
        guard = 0;
        while (beat < stop_at && guard < 20000) begin
            ph = phase_of(beat);
            src_valid = ($urandom_range(0, 3) != 0);
            if (ph == 2 && beat - CONV == 400 && drops < 5) begin
                src_valid = 1'b0;
                drops++;
            end
            src_data = 10'($urandom);
            core_fc_req = ~core_fc_req;
            start = ($urandom_range(0, 15) == 0);
            core_done = ($urandom_range(0, 15) == 0);
            core_class = 4'($urandom);
            #1;
            rdy = (ph == 1 || ph == 2) ? 1'b1 : (ph == 3) ? core_fc_req : 1'b0;
            chk("src_ready", src_ready, rdy);
            if (src_valid && rdy) begin
                e = '{tag: cyc + 1, en: 2'b00, cb: 1'b0, pv: 1'b0,
                      pb: 1'b0, fv: 1'b0, fw: 10'd0};
                if (ph == 1) begin
                    e.en = 2'b01 << (beat / KT);
                    e.cb = src_data[0];
                end else if (ph == 2) begin
                    e.pv = 1'b1;
                    e.pb = src_data[0];
                end else begin
                    e.fv = 1'b1;
                    e.fw = src_data;
                end
                sbq.push_back(e);
                beat++;
            end
            @(negedge clk);
            guard++;
        end
        chk("stream_budget", guard < 20000, 1);
        src_valid = 1'b0;
        start = 1'b0;
        core_done = 1'b0;
    endtask

    task automatic check_counts();
        chk("sb_drained", sbq.size(), 0);
        chk("n_conv", n_conv, CONV);
        chk("n_pix", n_pix, PIX);
        chk("n_fc", n_fc, FCB);
    endtask

    // Called at the first negedge in WAIT_RES
    task automatic finish_ok(input logic [3:0] cls);
        chk("busy_wait", busy, 1);
        chk("ready_wait", src_ready, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat ($urandom_range(0, 4)) @(negedge clk);
        chk("no_early_done", n_done, 0);
        core_done = 1'b1;
        core_class = cls;
        @(negedge clk);
        core_done = 1'b0;
        core_class = 4'($urandom);
        chk("done_pulse", done, 1);
        chk("class_out", class_out, cls);
        chk("err_clear", err, 0);
        @(negedge clk);
        chk("done_low", done, 0);
        chk("busy_idle", busy, 0);
        chk("class_hold", class_out, cls);
        chk("n_done", n_done, 1);
    endtask

    initial begin
        logic [3:0] cls;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_class", class_out, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", src_ready, 0);
        chk("rst_conv_en", conv_w_en, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_fc_wvalid", fc_wvalid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Run 1: full inference, class 7
        start_run();
        stream(TOTAL);
        check_counts();
        finish_ok(4'd7);

        // Run 2: abort at pixel 100, then restart
        start_run();
        stream(CONV + 100);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_pix", pix_valid, 0);
        chk("abort_class", class_out, 0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_done", n_done, 0);
        chk("abort_idle", busy, 0);
        start_run();
        stream(TOTAL);
        check_counts();
        cls = 4'($urandom);
        finish_ok(cls);

        // Run 3: withhold core_done
        start_run();
        stream(TOTAL);
        check_counts();
`ifdef BNN_SEQ_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            chk("to_no_done", done, 0);
            @(negedge clk);
        end
        chk("to_done", done, 1);
        chk("to_err", err, 1);
        chk("to_class", class_out, 4'hF);
        @(negedge clk);
        chk("to_idle", busy, 0);
        chk("to_err_hold", err, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("to_err_cleared", err, 0);
        chk("to_class_cleared", class_out, 0);
`else
        repeat (40) @(negedge clk);
        chk("wait_forever_busy", busy, 1);
        chk("wait_forever_err", err, 0);
        finish_ok(4'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
